// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Raster timing generator for 640x480@60Hz VGA (defaults), clocked at the
//   25 MHz pixel clock. It produces beam coordinates, an active-video flag,
//   the hsync/vsync pulses and line/frame start strobes.
//
// Ports
//   clk          in   pixel clock; every state change happens on its rising edge
//   rst_n        in   asynchronous active-low reset
//   x            out  [9:0] horizontal position, 0..H_TOTAL-1
//   y            out  [9:0] vertical position, 0..V_TOTAL-1
//   active       out  visible-area flag for the presented (x,y)
//   hsync        out  horizontal sync, polarity selected by SYNC_POL
//   vsync        out  vertical sync, polarity selected by SYNC_POL
//   line_start   out  one-cycle strobe while x==0 is presented
//   frame_start  out  one-cycle strobe while (x,y)==(0,0) is presented
//
// All outputs are registered and aligned. The decode is done on the
// next-state counter values, so every flag describes the coordinate shown
// in the same cycle. H_TOTAL and V_TOTAL must both be <= 1024.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
);

  // Sums are formed at full integer width and only then narrowed to the
  // 10-bit compare width of the counters.
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Level driven on hsync/vsync while the pulse is asserted.
  localparam logic SYNC_ON = (SYNC_POL != 0) ? 1'b1 : 1'b0;

  // ST_IDLE is the 'not running' condition after reset: the first edge out
  // of it presents (0,0) instead of advancing, so pixel (0,0) is never lost.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t     state, state_nx;
  logic [9:0] x_nx, y_nx;
  logic       active_nx, hsync_nx, vsync_nx, line_start_nx, frame_start_nx;
  logic       h_in_sync, v_in_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state counters.
  always_comb begin
    state_nx = ST_RUN;
    x_nx     = 10'd0;
    y_nx     = 10'd0;
    case (state)
      ST_IDLE: begin
        x_nx = 10'd0;
        y_nx = 10'd0;
      end
      ST_RUN: begin
        if (x == H_LAST) begin
          x_nx = 10'd0;
          y_nx = (y == V_LAST) ? 10'd0 : y + 10'd1;
        end else begin
          x_nx = x + 10'd1;
          y_nx = y;
        end
      end
      default: begin
        x_nx = 10'd0;
        y_nx = 10'd0;
      end
    endcase
  end

  // Output decode from the next-state coordinates.
  always_comb begin
    h_in_sync      = (x_nx >= H_SYNC_BEG) && (x_nx < H_SYNC_END);
    v_in_sync      = (y_nx >= V_SYNC_BEG) && (y_nx < V_SYNC_END);
    active_nx      = (x_nx < H_ACT_END) && (y_nx < V_ACT_END);
    hsync_nx       = h_in_sync ? SYNC_ON : ~SYNC_ON;
    vsync_nx       = v_in_sync ? SYNC_ON : ~SYNC_ON;
    line_start_nx  = (x_nx == 10'd0);
    frame_start_nx = (x_nx == 10'd0) && (y_nx == 10'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= 10'd0;
      y           <= 10'd0;
      active      <= 1'b0;
      hsync       <= ~SYNC_ON;
      vsync       <= ~SYNC_ON;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      x           <= x_nx;
      y           <= y_nx;
      active      <= active_nx;
      hsync       <= hsync_nx;
      vsync       <= vsync_nx;
      line_start  <= line_start_nx;
      frame_start <= frame_start_nx;
    end
  end

endmodule
